// File: rtl/gray_sdram_writer_if.sv
// Bus bundle for the grayscale-to-SDRAM writer: the pixel stream coming
// in from the grayscale stage and the SDRAM write port going out.
interface gray_sdram_writer_if;
  logic [9:0]  i_color;
  logic        i_bw;
  logic        i_valid;
  logic        i_wr_full;
  logic        o_write_request;
  logic [15:0] o_wr_data1;
  logic [15:0] o_wr_data2;

  // Writer side: consumes pixels and SDRAM full, drives the write strobe/data.
  modport slave (
    input  i_color, i_bw, i_valid, i_wr_full,
    output o_write_request, o_wr_data1, o_wr_data2
  );

  // Environment side: produces pixels and SDRAM full, observes writes.
  modport master (
    output i_color, i_bw, i_valid, i_wr_full,
    input  o_write_request, o_wr_data1, o_wr_data2
  );
endinterface

// File: rtl/gray_sdram_writer.sv
// Grayscale frame writer: buffers the incoming grayscale pixel stream in a
// small FIFO and writes each pixel to the SDRAM write port as R=G=B.
// Counts one frame of NUM_PIXEL input pixels, drains the FIFO, then pulses
// o_done. Pixels arriving while the FIFO is full (and nothing pops) are
// dropped and flagged on the sticky o_overflow.
// Build option: define GRAY_BW_OUTPUT_EN to write the binary frame
// (i_bw ? 0 : 1023) instead of the luma value.
module gray_sdram_writer #(
  parameter int NUM_PIXEL  = 307200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  gray_sdram_writer_if.slave   bus_if,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_overflow
);

  localparam int              DATA_W  = 10;
  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam logic [19:0]     LP_LAST = 20'(NUM_PIXEL - 1);
  localparam logic [AW:0]     LP_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [19:0]           r_in_cnt;
  logic                  r_overflow;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic [DATA_W-1:0]     r_mem [FIFO_DEPTH];
  logic                  r_wr_req_p1;
  logic [15:0]           r_wr_data1_p1;
  logic [15:0]           r_wr_data2_p1;

  logic                  w_start;
  logic                  w_take;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [DATA_W-1:0]     w_pix_value;
  logic [DATA_W-1:0]     w_head;

  // SDRAM word 1 carries the upper green bits alongside blue.
  function automatic logic [15:0] f_pack_hi(input logic [DATA_W-1:0] v);
    return {1'b0, v[9:5], v};
  endfunction

  // SDRAM word 2 carries the lower green bits alongside red.
  function automatic logic [15:0] f_pack_lo(input logic [DATA_W-1:0] v);
    return {1'b0, v[4:0], v};
  endfunction

  assign w_start = (r_state == S_IDLE) && i_start;
  assign w_take  = (r_state == S_WRITE) && bus_if.i_valid;
  assign w_full  = (r_count == LP_FULL);
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && !bus_if.i_wr_full;
  assign w_push  = w_take && (!w_full || w_pop);
  assign w_drop  = w_take && w_full && !w_pop;
  assign w_head  = r_mem[r_rd_ptr];

  // Select the value written to all three colour channels.
  always_comb begin
`ifdef GRAY_BW_OUTPUT_EN
    w_pix_value = bus_if.i_bw ? '0 : '1;
`else
    w_pix_value = bus_if.i_color;
`endif
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_WRITE;
      S_WRITE: if (w_take && (r_in_cnt == LP_LAST)) w_state_next = S_DRAIN;
      S_DRAIN: if (w_empty) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Pixel counter, overflow flag and FIFO pointers/occupancy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_in_cnt   <= '0;
      r_overflow <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_start) begin
        r_in_cnt   <= '0;
        r_overflow <= 1'b0;
      end else if (w_take) begin
        r_in_cnt <= r_in_cnt + 20'd1;
      end
      if (w_drop) r_overflow <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --- stage p0: FIFO storage (full+pop reads the old entry before overwrite)
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_pix_value;
  end

  // --- stage p1: registered write strobe and packed SDRAM words
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_req_p1   <= 1'b0;
      r_wr_data1_p1 <= '0;
      r_wr_data2_p1 <= '0;
    end else begin
      r_wr_req_p1 <= w_pop;
      if (w_pop) begin
        r_wr_data1_p1 <= f_pack_hi(w_head);
        r_wr_data2_p1 <= f_pack_lo(w_head);
      end
    end
  end

  assign bus_if.o_write_request = r_wr_req_p1;
  assign bus_if.o_wr_data1      = r_wr_data1_p1;
  assign bus_if.o_wr_data2      = r_wr_data2_p1;
  assign o_busy                 = (r_state == S_WRITE) || (r_state == S_DRAIN);
  assign o_done                 = (r_state == S_DONE);
  assign o_overflow             = r_overflow;

endmodule
